// File: rtl/six_instr_proc_p.sv
// Six-instruction multicycle accumulator-less processor: 16 x DW register file,
// 256 x DW data memory, external instruction ROM, three-process control FSM.
module six_instr_proc_p #(
  parameter int DW   = 16,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [PC_W-1:0] PC,
  output logic [15:0]     Instr,
  output logic [DW-1:0]   Rp_data,
  output logic [DW-1:0]   Rq_data,
  output logic [DW-1:0]   alu_out,
  output logic            RF_RP_zero,
  output logic [3:0]      cstate,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_LOAD = 4'd3,
    S_STORE  = 4'd4,  S_ADD   = 4'd5,  S_LDC    = 4'd6, S_SUB  = 4'd7,
    S_JMPZ   = 4'd8,  S_JMPZ_T = 4'd9, S_JMP    = 4'd10, S_HALT = 4'd11
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_LDC   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_JMPZ  = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } dec_t;

  state_t            state, nxt;
  dec_t              dec;
  logic [7:0]        d;
  logic              is_rr;
  logic [PC_W-1:0]   d_sext, jmp_tgt;
  logic [15:0][DW-1:0] rf;
  logic [DW-1:0]     dmem [256];
  logic [DW-1:0]     wd;
  logic              pc_clr, pc_inc, pc_jmp, ir_ld, rf_we, dm_we, ill_set;

  assign dec       = dec_t'(Instr);
  assign d         = Instr[7:0];
  assign imem_addr = PC;
  assign cstate    = state;
  assign halted    = (state == S_HALT);

  // ADD/SUB read rb/rc; every other instruction looks at ra on both ports.
  assign is_rr      = (dec.op == OP_ADD) || (dec.op == OP_SUB);
  assign Rp_data    = rf[is_rr ? dec.rb : dec.ra];
  assign Rq_data    = rf[is_rr ? dec.rc : dec.ra];
  assign RF_RP_zero = (Rp_data == '0);
  assign alu_out    = (dec.op == OP_SUB) ? (Rp_data - Rq_data) : (Rp_data + Rq_data);

  if (PC_W > 8) begin : g_sext_wide
    assign d_sext = {{(PC_W-8){Instr[7]}}, Instr[7:0]};
  end else begin : g_sext_narrow
    assign d_sext = Instr[PC_W-1:0];
  end

  // PC already points past the branch, hence the -1.
  assign jmp_tgt = PC + d_sext - PC_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= nxt;
  end

  always_comb begin
    nxt = S_INIT;
    case (state)
      S_INIT:   nxt = start ? S_FETCH : S_INIT;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (dec.op)
          OP_LOAD:  nxt = S_LOAD;
          OP_STORE: nxt = S_STORE;
          OP_ADD:   nxt = S_ADD;
          OP_LDC:   nxt = S_LDC;
          OP_SUB:   nxt = S_SUB;
          OP_JMPZ:  nxt = S_JMPZ;
          OP_JMP:   nxt = S_JMP;
          default:  nxt = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_LDC, S_SUB, S_JMPZ_T, S_JMP: nxt = S_FETCH;
      S_JMPZ:   nxt = RF_RP_zero ? S_JMPZ_T : S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_INIT;
    endcase
  end

  always_comb begin
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    pc_jmp  = 1'b0;
    ir_ld   = 1'b0;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    ill_set = 1'b0;
    case (state)
      S_INIT:                         pc_clr = 1'b1;
      S_FETCH:                        begin ir_ld = 1'b1; pc_inc = 1'b1; end
      S_DECODE:                       ill_set = dec.op[3];
      S_LOAD, S_ADD, S_LDC, S_SUB:    rf_we = 1'b1;
      S_STORE:                        dm_we = 1'b1;
      S_JMPZ_T, S_JMP:                pc_jmp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wd = alu_out;
    case (state)
      S_LOAD:  wd = dmem[d];
      S_LDC:   wd = DW'(d);
      default: wd = alu_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC      <= '0;
      Instr   <= '0;
      illegal <= 1'b0;
      rf      <= '0;
    end else begin
      if (pc_clr)      PC <= '0;
      else if (pc_inc) PC <= PC + PC_W'(1);
      else if (pc_jmp) PC <= jmp_tgt;
      if (ir_ld)   Instr <= imem_data;
      if (ill_set) illegal <= 1'b1;
      if (rf_we)   rf[dec.ra] <= wd;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (dm_we) dmem[d] <= Rp_data;
  end

endmodule

// File: tb/tb_six_instr_proc_p.sv
// Directed bench for six_instr_proc_p: ALU vector table plus hand sequences
// for reset, the memory program, branches, wrap and illegal opcode.
module tb_six_instr_proc_p;

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b1;
  logic [15:0] rom [256];
  logic [7:0]  imem_addr, PC;
  logic [15:0] imem_data, Instr;
  logic [15:0] Rp_data, Rq_data, alu_out;
  logic        RF_RP_zero, halted, illegal;
  logic [3:0]  cstate;

  logic        r8 = 1'b0, s8 = 1'b0;
  logic [15:0] rom8 [16];
  logic [3:0]  ia8, pc8, cs8;
  logic [15:0] id8, in8;
  logic [7:0]  rp8, rq8, alu8;
  logic        z8, h8, il8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];
  assign id8       = rom8[ia8];

  six_instr_proc_p dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .PC(PC), .Instr(Instr), .Rp_data(Rp_data), .Rq_data(Rq_data), .alu_out(alu_out),
    .RF_RP_zero(RF_RP_zero), .cstate(cstate), .halted(halted), .illegal(illegal)
  );

  six_instr_proc_p #(.DW(8), .PC_W(4)) dut8 (
    .clk(clk), .reset(r8), .start(s8), .imem_addr(ia8), .imem_data(id8),
    .PC(pc8), .Instr(in8), .Rp_data(rp8), .Rq_data(rq8), .alu_out(alu8),
    .RF_RP_zero(z8), .cstate(cs8), .halted(h8), .illegal(il8)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
  endtask

  task automatic restart();
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(negedge clk); reset = 1'b1; start = 1'b1;
  endtask

  task automatic wait_st(input string nm, input logic [3:0] st, input logic [7:0] pc, input int budget);
    int k = 0;
    while (!(cstate == st && PC == pc) && k < budget) begin @(negedge clk); k++; end
    check(nm, {31'd0, (cstate == st && PC == pc)}, 32'd1);
  endtask

  task automatic wait8(input string nm, input logic [3:0] st, input logic [3:0] pc, input int budget);
    int k = 0;
    while (!(cs8 == st && pc8 == pc) && k < budget) begin @(negedge clk); k++; end
    check(nm, {31'd0, (cs8 == st && pc8 == pc)}, 32'd1);
  endtask

  task automatic wait_halt(input string nm, input int budget);
    int k = 0;
    while (!halted && k < budget) begin @(negedge clk); k++; end
    check(nm, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{op:4'h2, dst:4'h3, rb:4'h1, rc:4'h2, a:8'h05, b:8'h03, exp:16'h0008};
    vecs[1] = '{op:4'h4, dst:4'h3, rb:4'h1, rc:4'h2, a:8'h05, b:8'h03, exp:16'h0002};
    vecs[2] = '{op:4'h4, dst:4'h3, rb:4'h2, rc:4'h1, a:8'h05, b:8'h03, exp:16'hFFFE};
    vecs[3] = '{op:4'h2, dst:4'h1, rb:4'h1, rc:4'h2, a:8'hFF, b:8'h01, exp:16'h0100};
    vecs[4] = '{op:4'h4, dst:4'h2, rb:4'h1, rc:4'h2, a:8'h10, b:8'h30, exp:16'hFFE0};
    vecs[5] = '{op:4'h2, dst:4'h3, rb:4'h1, rc:4'h1, a:8'h80, b:8'h00, exp:16'h0100};
    vecs[6] = '{op:4'h2, dst:4'h3, rb:4'h0, rc:4'h0, a:8'h07, b:8'h09, exp:16'h0000};
    vecs[7] = '{op:4'h4, dst:4'h1, rb:4'h1, rc:4'h1, a:8'hAB, b:8'h00, exp:16'h0000};

    // Reset with start high, then release into the LDC/SUB/STORE/LOAD program.
    clear_rom();
    rom[0] = 16'h3105; rom[1] = 16'h3203; rom[2] = 16'h4312;
    rom[3] = 16'h1310; rom[4] = 16'h0410; rom[5] = 16'h7400;
    step(2);
    check("rst cstate", cstate, 0);
    check("rst PC", PC, 0);
    check("rst Instr", Instr, 0);
    check("rst halted", halted, 0);
    check("rst illegal", illegal, 0);
    start = 1'b0; reset = 1'b1;
    step(2);
    check("init hold", cstate, 0);
    start = 1'b1;
    step(1);
    check("first fetch st", cstate, 1);
    check("first fetch PC", PC, 0);
    step(1);
    check("decode st", cstate, 2);
    check("PC after fetch", PC, 1);
    check("Instr loaded", Instr, 16'h3105);
    step(1);
    check("ldc st", cstate, 6);
    step(14);
    check("not yet halted", halted, 0);
    step(1);
    check("prog halted", halted, 1);
    check("prog halt st", cstate, 11);
    check("prog R4", Rp_data, 2);
    check("prog illegal", illegal, 0);
    step(5);
    check("halt PC frozen", PC, 6);
    check("halt held", cstate, 11);

    // ALU vector table.
    for (int i = 0; i < 8; i++) begin
      clear_rom();
      rom[0] = {4'h3, 4'h1, vecs[i].a};
      rom[1] = {4'h3, 4'h2, vecs[i].b};
      rom[2] = {vecs[i].op, vecs[i].dst, vecs[i].rb, vecs[i].rc};
      rom[3] = {4'h7, vecs[i].dst, 8'h00};
      restart();
      wait_st($sformatf("alu[%0d] exec reached", i), (vecs[i].op == 4'h2) ? 4'd5 : 4'd7, 8'd3, 20);
      check($sformatf("alu[%0d] alu_out", i), alu_out, vecs[i].exp);
      wait_halt($sformatf("alu[%0d] halt", i), 20);
      check($sformatf("alu[%0d] Rdst", i), Rp_data, vecs[i].exp);
    end

    // JMPZ taken then not taken, both at address 4 with d=-2.
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[0] = (t == 0) ? 16'h3100 : 16'h3101;
      rom[1] = 16'h3207; rom[2] = 16'h3308; rom[3] = 16'h3409; rom[4] = 16'h51FE;
      restart();
      wait_st($sformatf("jmpz%0d fetch4", t), 4'd1, 8'd4, 30);
      step(2);
      check($sformatf("jmpz%0d st", t), cstate, 8);
      check($sformatf("jmpz%0d zero", t), RF_RP_zero, (t == 0) ? 1 : 0);
      step(1);
      if (t == 0) begin
        check("jmpz taken st", cstate, 9);
        step(1);
      end
      check($sformatf("jmpz%0d next fetch st", t), cstate, 1);
      check($sformatf("jmpz%0d next addr", t), imem_addr, (t == 0) ? 2 : 5);
    end

    // Illegal opcode.
    clear_rom();
    rom[0] = 16'hA000;
    restart();
    step(2);
    check("ill decode", cstate, 2);
    step(1);
    check("ill st", cstate, 11);
    check("ill flag", illegal, 1);
    check("ill halted", halted, 1);
    step(4);
    check("ill PC frozen", PC, 1);

    // Reset asserted while in ADD: immediate INIT, destination not written.
    clear_rom();
    rom[0] = 16'h3105; rom[1] = 16'h3203; rom[2] = 16'h2312; rom[3] = 16'h7300;
    restart();
    step(1);
    check("illegal cleared", illegal, 0);
    wait_st("midadd reached", 4'd5, 8'd3, 20);
    check("midadd alu", alu_out, 8);
    reset = 1'b0;
    #1;
    check("midadd cstate", cstate, 0);
    check("midadd PC", PC, 0);
    check("midadd Instr", Instr, 0);
    @(negedge clk);
    clear_rom();
    rom[0] = 16'h7300;
    reset = 1'b1; start = 1'b1;
    wait_halt("midadd rerun halt", 10);
    check("midadd R3", Rp_data, 0);

    // DW=8 wrap on ADD, PC_W=4 wrap on fetch and JMP.
    for (int i = 0; i < 16; i++) rom8[i] = 16'h7000;
    rom8[0] = 16'h31FF; rom8[1] = 16'h3201; rom8[2] = 16'h2312;
    rom8[3] = 16'h530C; rom8[15] = 16'h6001;
    @(negedge clk); r8 = 1'b0; s8 = 1'b0;
    @(negedge clk); r8 = 1'b1; s8 = 1'b1;
    wait8("w8 add reached", 4'd5, 4'd3, 20);
    check("w8 alu", alu8, 8'h00);
    check("w8 rp", rp8, 8'hFF);
    check("w8 rq", rq8, 8'h01);
    wait8("w8 jmpz reached", 4'd8, 4'd4, 10);
    check("w8 R3 zero", z8, 1);
    wait8("w8 fetch15", 4'd1, 4'd15, 10);
    step(1);
    check("w8 fetch wrap", pc8, 0);
    step(1);
    check("w8 jmp st", cs8, 10);
    step(1);
    check("w8 jmp st fetch", cs8, 1);
    check("w8 jmp addr", ia8, 0);
    check("w8 illegal", il8, 0);
    check("w8 halted", h8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
